// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Defines shared by the IF, ID and EXE stages: the default datapath width,
// the default reset PC, the NOP encoding and the sequential PC step.
// No ports; import with `import fetch_unit_pkg::*;`.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int          DEF_WORD_LEN = 32;
  localparam logic [31:0] DEF_PC_RESET = 32'h0000_0000;

  // All-zero word acts as a NOP downstream; an empty IF/ID resets to it.
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam int          PC_STEP      = 4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// One-entry holding register used by the fetch stage. It catches a word
// returned by instruction memory while ID is frozen, so the word is neither
// lost nor fetched a second time.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   clear                 drop the held word (redirect); highest priority
//   load                  capture load_instr/load_pc4, set buf_valid
//   drain                 the held word is being consumed, clear buf_valid
//   load_instr, load_pc4  word and its PC+4 to capture
//   buf_instr, buf_pc4    held word and its PC+4
//   buf_valid             entry is occupied
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic                drain,
  input  logic [WORD_LEN-1:0] load_instr,
  input  logic [WORD_LEN-1:0] load_pc4,
  output logic [WORD_LEN-1:0] buf_instr,
  output logic [WORD_LEN-1:0] buf_pc4,
  output logic                buf_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_instr <= WORD_LEN'(NOP_INSTR);
      buf_pc4   <= '0;
      buf_valid <= 1'b0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_instr <= load_instr;
      buf_pc4   <= load_pc4;
      buf_valid <= 1'b1;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

endmodule : fetch_buffer

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, issues
// requests over a req/ready handshake (data valid in the accepting cycle),
// and presents fetched words to ID. hazard_detected freezes the IF->ID flow;
// branch_taken redirects the PC unless it coincides with a hazard.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   hazard_detected  ID hazard, freezes IF/ID
//   branch_taken     ID branch resolved taken
//   branch_address   redirect target
//   imem_req         fetch request (low while the holding buffer is full)
//   imem_addr        fetch address (= pc)
//   imem_ready       request accepted, imem_rdata valid this cycle
//   imem_rdata       fetched instruction
//   instr_ID, PC_ID  IF/ID instruction and its PC+4
//   valid_ID         IF/ID holds a real instruction (0 = bubble)
//   stall_cycles     cycles with freeze asserted (saturating)
//   flush_count      number of redirects (saturating)
//
// Build option: define FETCH_PERF_EN to instantiate the two performance
// counters; otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 WORD_LEN = DEF_WORD_LEN,
  parameter logic [WORD_LEN-1:0] PC_RESET = DEF_PC_RESET
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_address,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] instr_ID,
  output logic [WORD_LEN-1:0] PC_ID,
  output logic                valid_ID,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
);

  logic [WORD_LEN-1:0] pc_reg;
  logic [WORD_LEN-1:0] pc_plus4;
  logic                redirect;
  logic                freeze;
  logic                fire;

  logic [WORD_LEN-1:0] buf_instr;
  logic [WORD_LEN-1:0] buf_pc4;
  logic                buf_valid;

  // A branch that arrives together with a hazard is itself stalled in ID,
  // so it must not steer the PC yet.
  assign redirect = branch_taken & ~hazard_detected;
  assign freeze   = hazard_detected;

  assign imem_req  = ~buf_valid;
  assign imem_addr = pc_reg;
  assign fire      = imem_req & imem_ready;
  assign pc_plus4  = pc_reg + WORD_LEN'(PC_STEP);  // wraps silently

  fetch_buffer #(
    .WORD_LEN (WORD_LEN)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect),
    .load       (freeze & fire),
    .drain      (~redirect & ~freeze & buf_valid),
    .load_instr (imem_rdata),
    .load_pc4   (pc_plus4),
    .buf_instr  (buf_instr),
    .buf_pc4    (buf_pc4),
    .buf_valid  (buf_valid)
  );

  // PC and IF/ID register. Priority: redirect > freeze > normal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg   <= PC_RESET;
      instr_ID <= WORD_LEN'(NOP_INSTR);
      PC_ID    <= '0;
      valid_ID <= 1'b0;
    end else if (redirect) begin
      // Any word returned this cycle belongs to the wrong path: drop it.
      pc_reg   <= branch_address;
      valid_ID <= 1'b0;
    end else if (freeze) begin
      // IF/ID holds; a word fetched now lands in the buffer instead.
      if (fire) begin
        pc_reg <= pc_plus4;
      end
    end else if (buf_valid) begin
      // Buffered word goes first; no request is issued this cycle.
      instr_ID <= buf_instr;
      PC_ID    <= buf_pc4;
      valid_ID <= 1'b1;
    end else if (fire) begin
      instr_ID <= imem_rdata;
      PC_ID    <= pc_plus4;
      valid_ID <= 1'b1;
      pc_reg   <= pc_plus4;
    end else begin
      valid_ID <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_reg;
  logic [31:0] flush_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
      flush_reg <= '0;
    end else begin
      if (freeze && (stall_reg != 32'hFFFF_FFFF)) begin
        stall_reg <= stall_reg + 32'd1;
      end
      if (redirect && (flush_reg != 32'hFFFF_FFFF)) begin
        flush_reg <= flush_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_reg;
  assign flush_count  = flush_reg;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Instruction memory returns addr ^ 32'h5A5A0000
// combinationally; every expected value below is a hand-computed constant.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        hazard_detected;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_ID;
  logic [31:0] PC_ID;
  logic        valid_ID;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instr_ID        (instr_ID),
    .PC_ID           (PC_ID),
    .valid_ID        (valid_ID),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'h5A5A_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one rising edge, land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare the IF/ID register and fetch port in one go.
  task automatic check_stage(input string tag, input logic [31:0] e_addr, input logic e_req,
                             input logic e_valid, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4);
    check({tag, ".addr"},  imem_addr, e_addr);
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, e_req});
    check({tag, ".valid"}, {31'd0, valid_ID}, {31'd0, e_valid});
    if (e_valid) begin
      check({tag, ".instr"}, instr_ID, e_instr);
      check({tag, ".pc4"},   PC_ID, e_pc4);
    end
  endtask

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
`ifdef FETCH_PERF_EN
    exp_stall = 32'd5;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif

    rst             = 1'b1;
    hazard_detected = 1'b0;
    branch_taken    = 1'b0;
    branch_address  = 32'h0;
    imem_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    check("rst.addr",  imem_addr, 32'h0);
    check("rst.req",   {31'd0, imem_req}, 32'd1);
    check("rst.valid", {31'd0, valid_ID}, 32'd0);
    check("rst.instr", instr_ID, 32'h0);
    check("rst.pc4",   PC_ID, 32'h0);
    check("rst.stall", stall_cycles, 32'h0);
    check("rst.flush", flush_count, 32'h0);
    rst = 1'b0;

    // Straight-line fetch 0, 4, 8.
    step(); check_stage("seq0", 32'h4,  1'b1, 1'b1, 32'h5A5A_0000, 32'h4);
    step(); check_stage("seq1", 32'h8,  1'b1, 1'b1, 32'h5A5A_0004, 32'h8);
    step(); check_stage("seq2", 32'hC,  1'b1, 1'b1, 32'h5A5A_0008, 32'hC);

    // Three freeze cycles: word at 12 is buffered, IF/ID keeps word 8.
    hazard_detected = 1'b1;
    step(); check_stage("frz0", 32'h10, 1'b0, 1'b1, 32'h5A5A_0008, 32'hC);
    step(); check_stage("frz1", 32'h10, 1'b0, 1'b1, 32'h5A5A_0008, 32'hC);
    step(); check_stage("frz2", 32'h10, 1'b0, 1'b1, 32'h5A5A_0008, 32'hC);
    hazard_detected = 1'b0;
    step(); check_stage("drain", 32'h10, 1'b1, 1'b1, 32'h5A5A_000C, 32'h10);
    step(); check_stage("post",  32'h14, 1'b1, 1'b1, 32'h5A5A_0010, 32'h14);

    // Fill the buffer, then redirect to 0x100 with the buffer full.
    hazard_detected = 1'b1;
    step(); check_stage("fill", 32'h18, 1'b0, 1'b1, 32'h5A5A_0010, 32'h14);
    hazard_detected = 1'b0;
    branch_taken    = 1'b1;
    branch_address  = 32'h100;
    step(); check_stage("redir", 32'h100, 1'b1, 1'b0, 32'h0, 32'h0);
    branch_taken = 1'b0;
    step(); check_stage("tgt", 32'h104, 1'b1, 1'b1, 32'h5A5A_0100, 32'h104);

    // Branch together with a hazard: ignored, freeze only.
    hazard_detected = 1'b1;
    branch_taken    = 1'b1;
    branch_address  = 32'h200;
    step(); check_stage("bhz", 32'h108, 1'b0, 1'b1, 32'h5A5A_0100, 32'h104);
`ifdef FETCH_PERF_EN
    check("bhz.flush", flush_count, 32'd1);
`else
    check("bhz.flush", flush_count, 32'd0);
`endif
    hazard_detected = 1'b0;
    branch_taken    = 1'b0;
    step(); check_stage("bhz.drain", 32'h108, 1'b1, 1'b1, 32'h5A5A_0104, 32'h108);

    // Memory not ready for two cycles: bubbles, address stable.
    imem_ready = 1'b0;
    step(); check_stage("nrdy0", 32'h108, 1'b1, 1'b0, 32'h0, 32'h0);
    step(); check_stage("nrdy1", 32'h108, 1'b1, 1'b0, 32'h0, 32'h0);
    imem_ready = 1'b1;
    step(); check_stage("rdy", 32'h10C, 1'b1, 1'b1, 32'h5A5A_0108, 32'h10C);

    // Redirect near the top of the address space, then wrap through zero.
    branch_taken   = 1'b1;
    branch_address = 32'hFFFF_FFF8;
    step(); check_stage("redir2", 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0, 32'h0);
    branch_taken = 1'b0;
    step(); check_stage("hi0",  32'hFFFF_FFFC, 1'b1, 1'b1, 32'hA5A5_FFF8, 32'hFFFF_FFFC);
    step(); check_stage("wrap", 32'h0,         1'b1, 1'b1, 32'hA5A5_FFFC, 32'h0);

    check("perf.stall", stall_cycles, exp_stall);
    check("perf.flush", flush_count, exp_flush);

    // Reset while frozen with the buffer full drops everything at once.
    hazard_detected = 1'b1;
    step(); check("mid.req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check_stage("mid.rst", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("mid.instr", instr_ID, 32'h0);
    check("mid.stall", stall_cycles, 32'h0);
    check("mid.flush", flush_count, 32'h0);
    hazard_detected = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(); check_stage("restart", 32'h4, 1'b1, 1'b1, 32'h5A5A_0000, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage with its IF/ID pipeline register, sitting directly upstream of the ID-stage hazard detection logic. It owns the PC, issues requests to instruction memory over a request/ready handshake, and presents fetched instructions to ID. It consumes `hazard_detected` (freeze) and the ID-stage branch resolution (flush/redirect). A one-entry holding buffer absorbs an instruction returned while ID is frozen, so no fetched word is lost or re-fetched.

## Interface
- `WORD_LEN`, 32, width of PC and instruction
- `PC_RESET`, 32'h0, PC value loaded on reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `hazard_detected`  in  1  ID-stage hazard; freezes PC-to-ID flow
- `branch_taken`  in  1  ID-stage branch resolved taken
- `branch_address`  in  WORD_LEN  redirect target
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  WORD_LEN  fetch address (= PC)
- `imem_ready`  in  1  request accepted; `imem_rdata` valid same cycle
- `imem_rdata`  in  WORD_LEN  fetched instruction
- `instr_ID`  out  WORD_LEN  IF/ID instruction
- `PC_ID`  out  WORD_LEN  IF/ID PC+4 of that instruction
- `valid_ID`  out  1  IF/ID holds a real instruction (0 = bubble)
- `stall_cycles`, `flush_count`  out  32 each  perf counters (see Configuration)

## Operation
- Registered state: `pc`, IF/ID (`instr_ID`, `PC_ID`, `valid_ID`), buffer (`buf_instr`, `buf_pc4`, `buf_valid`).
- Effective control: `redirect = branch_taken & ~hazard_detected`; `freeze = hazard_detected`. A branch seen together with a hazard is ignored (the branch itself is stalled in ID).
- `imem_req = ~buf_valid`; `imem_addr = pc`. Fetch "fires" when `imem_req & imem_ready`.
- Priority per cycle: reset > redirect > freeze > normal.
- Redirect: `pc <= branch_address`; `valid_ID <= 0`; `buf_valid <= 0`; any data firing that cycle is discarded.
- Freeze: IF/ID holds. If a fetch fires, word and `pc+4` go into the buffer, `buf_valid <= 1`, `pc <= pc+4`. Buffer full: no request, `pc` holds.
- Normal, `buf_valid=1`: buffer moves into IF/ID with `valid_ID <= 1`; `buf_valid <= 0`. No fetch that cycle.
- Normal, buffer empty: fire loads IF/ID (`instr_ID <= imem_rdata`, `PC_ID <= pc+4`, `valid_ID <= 1`), `pc <= pc+4`. No fire: `valid_ID <= 0` (bubble), `pc` holds.
- PC arithmetic modulo 2^WORD_LEN; wrap from 32'hFFFFFFFC to 0 is silent.
- `imem_addr` changes only after a fire or on redirect (request abandoned; memory tolerates this).

## Timing
- Reset values: `pc=PC_RESET`, `instr_ID=0`, `PC_ID=0`, `valid_ID=0`, `buf_valid=0`, counters 0; `imem_req=1` combinationally once `rst` deasserts.
- Fetch latency: fire in cycle n -> `instr_ID` valid in cycle n+1 (buffer path: first unfrozen cycle after n).
- Redirect in cycle n -> `imem_addr=branch_address` in cycle n+1, first target instruction in ID at n+2 at earliest.
- Reset asserted mid-freeze or with buffer full: all state cleared immediately, buffered word dropped.

## Configuration
- `FETCH_PERF_EN` defined: `stall_cycles` increments each cycle with `freeze=1`; `flush_count` increments each redirect; both saturate at 32'hFFFFFFFF.
- Undefined: counters not instantiated, both outputs tied to 0.

## Structure
- Shared defines header: `WORD_LEN`, `PC_RESET` default, instruction NOP encoding (32'h0), shared with ID/EXE stages.
- Sub-module `fetch_buffer`: one-entry holding register (load, drain, clear, `buf_valid`); the remainder of the PC/IF/ID logic stays in `fetch_unit`.

## Test plan
- Reset, `imem_ready=1` always, no hazards -> `imem_addr` 0,4,8,…; `instr_ID` matches memory one cycle later; `PC_ID` = addr+4.
- `hazard_detected` high 3 cycles after fetch of addr 8 -> word at 12 buffered, `imem_req=0`, IF/ID holds addr-8 word; on release addr-12 word enters ID, next fetch 16, no duplicates.
- `branch_taken=1`, `branch_address=32'h100` with buffer full -> `valid_ID=0`, buffer cleared, next `imem_addr=32'h100`.
- `branch_taken` and `hazard_detected` together -> redirect ignored, freeze behaviour only; `flush_count` unchanged.
- `imem_ready` low 2 cycles -> `imem_addr` stable, `valid_ID=0` bubbles, `pc` unchanged.
- With `FETCH_PERF_EN`: 5 freeze cycles and 2 redirects -> `stall_cycles=5`, `flush_count=2`; without it both read 0.
